// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Holds the FSM state encoding, the grant encoding (which requester owns the
// shared port) and the default address/data widths used by the arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_D_BUSY  = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } arb_gnt_e;

endpackage

// File: rtl/arb_watchdog.sv
// Watchdog for one outstanding memory transaction.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   clr          clear the count (asserted on grant)
//   en           count one BUSY cycle that saw no m_ack
//   expired      count has reached TIMEOUT-1
module arb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The arbiter leaves BUSY as soon as this fires, so the count never wraps.
  assign expired = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory port between an instruction-fetch requester
// and a data (load/store) requester, one transaction outstanding at a time.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   if_req/if_addr                 fetch request and word address
//   if_rvalid/if_rdata             fetch completion pulse and instruction
//   d_req/d_we/d_addr/d_wdata      data request, store flag, address, data
//   d_rvalid/d_rdata               data completion pulse and load data
//   m_req/m_we/m_addr/m_wdata      shared memory port request side
//   m_ack/m_rdata                  shared memory port completion
//   err                            pulses with rvalid of an aborted access
//   busy                           arbiter not IDLE (core stall)
//   dbg_state                      current FSM state, for observation
//
// Handshake: a requester raises req (level) with stable address/data and
// holds it until its rvalid pulse; rvalid is a single-cycle completion that
// carries rdata. On the memory side m_req stays high with stable
// m_addr/m_we/m_wdata until a single-cycle m_ack carrying m_rdata.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err,
  output logic              busy,
  output arb_state_e        dbg_state
);

  arb_state_e        state_q, state_d;
  arb_gnt_e          last_gnt_q, last_gnt_d;
  arb_gnt_e          gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              err_q, err_d;
  logic              in_busy;
  logic              wd_clr;
  logic              wd_expired;

  assign in_busy = (state_q == ST_IF_BUSY) || (state_q == ST_D_BUSY);

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (in_busy && !m_ack),
    .expired (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    err_d      = err_q;
    wd_clr     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          wd_clr = 1'b1;
          err_d  = 1'b0;
          // On a tie the requester that did not win last time goes first.
          if (d_req && (!if_req || last_gnt_q == GNT_FETCH)) begin
            gnt_d   = GNT_DATA;
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
            state_d = ST_D_BUSY;
          end else begin
            gnt_d   = GNT_FETCH;
            addr_d  = if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
            state_d = ST_IF_BUSY;
          end
        end
      end
      ST_IF_BUSY, ST_D_BUSY: begin
        // m_ack takes priority over an expiring watchdog in the same cycle.
        if (m_ack) begin
          state_d    = ST_RESP;
          last_gnt_d = gnt_q;
          err_d      = 1'b0;
          if (gnt_q == GNT_DATA) d_rdata_d = m_rdata;
          else                   if_rdata_d = m_rdata;
        end else if (wd_expired) begin
          // Abort counts as the requester's turn so the other side gets next tie.
          state_d    = ST_RESP;
          last_gnt_d = gnt_q;
          err_d      = 1'b1;
          if (gnt_q == GNT_DATA) d_rdata_d = '0;
          else                   if_rdata_d = '0;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= GNT_FETCH;
      gnt_q      <= GNT_FETCH;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      err_q      <= err_d;
    end
  end

  assign m_req     = in_busy;
  assign m_we      = we_q;
  assign m_addr    = addr_q;
  assign m_wdata   = wdata_q;
  assign if_rvalid = (state_q == ST_RESP) && (gnt_q == GNT_FETCH);
  assign d_rvalid  = (state_q == ST_RESP) && (gnt_q == GNT_DATA);
  assign err       = (state_q == ST_RESP) && err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule
